// File: rtl/stop_it_round_ctrl.sv
// Stop-It round sequencer: game FSM, pause timers, score keeping and
// single-cycle command strobes for the counter/target/comparator datapath.
module stop_it_round_ctrl #(
  parameter int START_CYCLES  = 8,
  parameter int RESULT_CYCLES = 16,
  parameter int WIN_COUNT     = 17,
  parameter int SCORE_W       = 5
) (
  input  logic               clk_4_i,
  input  logic               rst_i,
  input  logic               go_i,
  input  logic               stop_i,
  input  logic               load_i,
  input  logic               match_i,
  output logic [2:0]         state_o,
  output logic               cnt_load_o,
  output logic               cnt_dec_o,
  output logic               target_load_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               blink_o
);

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_CORR  = 3'd3;
  localparam logic [2:0] S_WRONG = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  localparam int MAXC = (START_CYCLES > RESULT_CYCLES) ?
                        START_CYCLES : RESULT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] START_LAST  = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_CYCLES - 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_COUNT);

  logic [2:0]         r_state;
  logic [TW-1:0]      r_timer;
  logic [SCORE_W-1:0] r_score;
  logic               r_blink;

  logic [2:0]         w_next;
  logic               w_start_done;
  logic               w_result_done;
  logic               w_hit;
  logic               w_timed;

  assign w_start_done  = (r_timer == START_LAST);
  assign w_result_done = (r_timer == RESULT_LAST);
  assign w_hit   = (r_state == S_DEC) && stop_i && match_i;
  assign w_timed = (r_state == S_START) ||
                   (r_state == S_CORR)  ||
                   (r_state == S_WRONG);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  if (go_i) w_next = S_START;
      S_START: if (w_start_done) w_next = S_DEC;
      S_DEC:   if (stop_i) w_next = match_i ? S_CORR : S_WRONG;
      S_CORR: begin
        if (w_result_done)
          w_next = (r_score >= WIN_SCORE) ? S_WON : S_WAIT;
      end
      S_WRONG: if (w_result_done) w_next = S_WAIT;
      S_WON:   w_next = S_WON;
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Timer restarts from zero on every state change.
  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= '0;
    end else if (w_timed) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      r_score <= '0;
    end else if (w_hit && (r_score != SCORE_MAX)) begin
      r_score <= r_score + 1'b1;
    end
  end

  // Blink phase follows the next state so it lines up with state_o.
  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      r_blink <= 1'b0;
    end else begin
      case (w_next)
        S_CORR:  r_blink <= 1'b1;
        S_WRONG,
        S_WON:   r_blink <= (w_next == r_state) ? ~r_blink : 1'b1;
        default: r_blink <= 1'b0;
      endcase
    end
  end

  assign state_o = r_state;
  assign score_o = r_score;
  assign blink_o = r_blink;

  assign cnt_load_o    = ~rst_i && (r_state == S_START) && w_start_done;
  assign cnt_dec_o     = ~rst_i && (r_state == S_DEC) && ~stop_i;
  assign target_load_o = ~rst_i && (r_state == S_WAIT) && load_i && ~go_i;

endmodule

// File: tb/tb_stop_it_round_ctrl.sv
// Randomized bench for stop_it_round_ctrl against a countdown-based
// behavioural model of the round rules.
module tb_stop_it_round_ctrl;

  localparam int START_C  = 8;
  localparam int RESULT_C = 16;
  localparam int WIN_C    = 17;
  localparam int SW       = 5;
  localparam int SMAX     = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic          stop = 1'b0;
  logic          load = 1'b0;
  logic          match = 1'b0;
  logic [2:0]    st;
  logic          cnt_load;
  logic          cnt_dec;
  logic          tload;
  logic [SW-1:0] score;
  logic          blink;

  stop_it_round_ctrl #(
    .START_CYCLES (START_C),
    .RESULT_CYCLES(RESULT_C),
    .WIN_COUNT    (WIN_C),
    .SCORE_W      (SW)
  ) dut (
    .clk_4_i      (clk),
    .rst_i        (rst),
    .go_i         (go),
    .stop_i       (stop),
    .load_i       (load),
    .match_i      (match),
    .state_o      (st),
    .cnt_load_o   (cnt_load),
    .cnt_dec_o    (cnt_dec),
    .target_load_o(tload),
    .score_o      (score),
    .blink_o      (blink)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: state name index, cycles left in timed states, score, blink.
  int m_state;
  int m_left;
  int m_score;
  bit m_blink;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_left  = 0;
    m_score = 0;
    m_blink = 1'b0;
  endtask

  task automatic check_outputs();
    chk("state", 32'(st), 32'(m_state));
    chk("score", 32'(score), 32'(m_score));
    chk("blink", 32'(blink), 32'(m_blink));
    chk("cnt_load", 32'(cnt_load),
        32'(!rst && m_state == 1 && m_left == 1));
    chk("cnt_dec", 32'(cnt_dec),
        32'(!rst && m_state == 2 && !stop));
    chk("target_load", 32'(tload),
        32'(!rst && m_state == 0 && load && !go));
  endtask

  task automatic m_step();
    if (rst) begin
      m_reset();
      return;
    end
    case (m_state)
      0: begin
        if (go) begin
          m_state = 1;
          m_left  = START_C;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) m_state = 2;
      end
      2: begin
        if (stop) begin
          m_left  = RESULT_C;
          m_blink = 1'b1;
          if (match) begin
            m_state = 3;
            if (m_score < SMAX) m_score++;
          end else begin
            m_state = 4;
          end
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          m_state = (m_score >= WIN_C) ? 5 : 0;
          m_blink = (m_state == 5);
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) begin
          m_state = 0;
          m_blink = 1'b0;
        end else begin
          m_blink = ~m_blink;
        end
      end
      default: m_blink = ~m_blink;
    endcase
  endtask

  // One clock of random stimulus; optionally a mid-cycle async reset.
  task automatic run_cycles(input int n, input bit always_match,
                            input bit allow_rst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst   = 1'b0;
      go    = ($urandom % 4) == 0;
      load  = ($urandom % 3) == 0;
      stop  = ($urandom % 5) == 0;
      match = always_match ? 1'b1 : 1'(($urandom % 2) == 0);
      #1 check_outputs();
      if (allow_rst && ($urandom % 120) == 0) begin
        rst = 1'b1;
        #1;
        m_reset();
        check_outputs();
      end
      @(posedge clk);
      m_step();
    end
  endtask

  initial begin
    m_reset();
    go = 1'b1;
    load = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 check_outputs();
      @(posedge clk);
      m_step();
    end
    run_cycles(2000, 1'b0, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    #1 m_reset();
    @(posedge clk);
    m_step();
    run_cycles(1500, 1'b1, 1'b0);
    chk("won_reached", 32'(st), 32'd5);
    chk("won_score", 32'(score), 32'(WIN_C));

    run_cycles(100, 1'b0, 1'b0);
    chk("won_absorbing", 32'(st), 32'd5);
    run_cycles(1500, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stop_it_round_ctrl.md
Name: stop_it_round_ctrl

Overview:
Round sequencer for the Stop-It game datapath. It owns the game FSM and pause timers, and commands an external counter/target/comparator datapath through single-cycle strobes. It keeps the correct-answer score and declares a win. It sits between the debounced button pulses and the counter/display datapath, all in the 4 Hz clock domain.

Parameters:
START_CYCLES, 8, clk_4_i cycles spent in STARTING (2 s at 4 Hz)
RESULT_CYCLES, 16, clk_4_i cycles spent in CORRECT or WRONG (4 s)
WIN_COUNT, 17, correct answers needed to enter WON
SCORE_W, 5, score width; must satisfy 2**SCORE_W > WIN_COUNT

Ports:
clk_4_i  in  1  4 Hz system clock
rst_i  in  1  asynchronous, active-high reset
go_i  in  1  start-round request (level, sampled on posedge)
stop_i  in  1  stop request
load_i  in  1  load-target request
match_i  in  1  datapath comparator: running counter equals target
state_o  out  3  encoded state: 0 WAITING_TO_START, 1 STARTING, 2 DECREMENTING, 3 CORRECT, 4 WRONG, 5 WON
cnt_load_o  out  1  load counter with 8'h1F
cnt_dec_o  out  1  decrement counter this cycle
target_load_o  out  1  capture switches into target register
score_o  out  SCORE_W  correct answers so far
blink_o  out  1  display blink phase

Behaviour:
- Reset (async assert, sync-to-clock release is not required): state WAITING_TO_START, timer 0, score 0, blink_o 0. All strobes are combinational decodes of registered state and inputs. Strobes are 0 while rst_i is high.
- WAITING_TO_START:
  - go_i=1 -> STARTING next edge, timer cleared.
  - load_i=1 with go_i=0 -> target_load_o=1 this cycle, stay in state.
  - go_i and load_i together -> go wins; target_load_o=0.
- STARTING:
  - Timer counts 0..START_CYCLES-1.
  - cnt_load_o=1 exactly on the cycle with timer==START_CYCLES-1, so the counter reads 1F on the first DECREMENTING cycle.
  - Transition to DECREMENTING exactly START_CYCLES edges after the go-sampling edge.
  - go_i, stop_i and load_i are ignored.
- DECREMENTING:
  - cnt_dec_o=1 every cycle where stop_i=0.
  - stop_i=1 -> cnt_dec_o=0 (stop beats decrement) and match_i is sampled on the same edge.
  - match_i=1 -> CORRECT and score increments (saturates at 2**SCORE_W-1).
  - match_i=0 -> WRONG.
  - No timeout; counter wrap is the datapath's concern.
- CORRECT / WRONG:
  - Timer counts RESULT_CYCLES edges from the stop-sampling edge.
  - Then: CORRECT -> WON if score >= WIN_COUNT, else WAITING_TO_START. WRONG -> WAITING_TO_START.
  - All inputs are ignored.
  - blink_o toggles every cycle in WRONG, is constant 1 in CORRECT, and is 0 in all other states.
- WON: absorbing. All inputs are ignored, blink_o toggles every cycle, and score is held. Only rst_i exits WON.
- Timer: $clog2(max(START_CYCLES,RESULT_CYCLES)) bits; cleared on every state change.
- Reset mid-round from any state: immediate return to WAITING_TO_START with score 0. There must be no residual strobe on the first post-reset cycle.
- Inputs held high across state boundaries are treated as levels, not edges. A go_i held through a round restarts the next round immediately on return to WAITING_TO_START.

Test Plan:
- Reset 2 cycles, pulse go_i 1 cycle -> state_o=1 next edge; cnt_load_o high only on the 8th STARTING cycle; state_o=2 exactly 8 edges after the go edge.
- In DECREMENTING, hold 5 cycles, then stop_i=1 with match_i=1 -> cnt_dec_o high 5 cycles and low on the stop cycle; state CORRECT; score_o=1; WAITING_TO_START exactly 16 edges later.
- stop_i with match_i=0 -> WRONG; blink_o toggles each cycle; score unchanged; WAITING_TO_START after 16 edges.
- 17 consecutive correct rounds -> score_o=17, state WON 16 edges after the 17th stop. Further go_i/stop_i have no effect; rst_i returns WAITING_TO_START with score 0.
- In WAITING_TO_START: load_i alone -> target_load_o=1 for 1 cycle. go_i+load_i together -> STARTING with target_load_o=0. stop_i alone -> no change.
- Assert rst_i asynchronously mid-STARTING and mid-CORRECT -> state_o=0 and all strobes 0 before the next clock edge; the next go_i gives full 8-cycle STARTING timing.
